// File: rtl/qu_common_pkg.sv
// Shared widths and payload types for the out-of-order core's queue structures.
package qu_common;

  localparam int unsigned ARCH_RD_WIDTH     = 5;
  localparam int unsigned PHY_RF_ADDR_WIDTH = 6;
  localparam int unsigned ROB_DEPTH_DEFAULT = 16;
  localparam int unsigned ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH_DEFAULT);

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;

  typedef struct packed {
    logic                         valid;
    logic                         done;
    logic [ARCH_RD_WIDTH-1:0]     arch_rd;
    logic [PHY_RF_ADDR_WIDTH-1:0] phy_rd;
    logic                         has_rd;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation and retirement, out-of-order completion,
// busy-table clear on completion and whole-buffer flush for recovery.
module rob
  import qu_common::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(ROB_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic [ARCH_RD_WIDTH-1:0]     alloc_arch_rd,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_phy_rd,
  input  logic                         alloc_has_rd,
  output logic [AW-1:0]                tail_ptr,
  output logic                         full,
  output logic                         empty,
  output logic [CW-1:0]                count,
  input  logic                         cmpl_en,
  input  logic [AW-1:0]                cmpl_addr,
  output logic                         commit_en,
  output logic [ARCH_RD_WIDTH-1:0]     commit_arch_rd,
  output logic [PHY_RF_ADDR_WIDTH-1:0] commit_phy_rd,
  output logic                         commit_has_rd,
  output logic                         busy_table_wr_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_wr_addr,
  output logic                         busy_table_wr_data,
  input  logic                         flush
);

  rob_entry_t        entries [ROB_DEPTH];
  logic [AW:0]       head;
  logic [AW:0]       tail;
  logic [AW:0]       head_n;
  logic [AW:0]       tail_n;
  logic [CW-1:0]     count_n;
  logic              full_n;
  logic              empty_n;
  logic              do_alloc;
  logic              do_cmpl;
  logic              do_commit;
  rob_entry_t        head_ent;
  rob_entry_t        cmpl_ent;

  assign tail_ptr = tail[AW-1:0];

  // Decide this edge's alloc/complete/commit and the resulting pointers and flags.
  always_comb begin
    head_ent  = entries[head[AW-1:0]];
    cmpl_ent  = entries[cmpl_addr];
    do_alloc  = alloc_en && !full;
    do_cmpl   = cmpl_en && cmpl_ent.valid && !cmpl_ent.done;
    do_commit = head_ent.valid && head_ent.done;
    head_n    = head + CW'(do_commit);
    tail_n    = tail + CW'(do_alloc);
    count_n   = count;
    case ({do_alloc, do_commit})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
    if (flush) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end
    empty_n = (head_n == tail_n);
    full_n  = (head_n[AW-1:0] == tail_n[AW-1:0]) && (head_n[AW] != tail_n[AW]);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      full  <= full_n;
      empty <= empty_n;
    end
  end

  // Entry storage; complete, retire and allocate always touch distinct slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (do_cmpl) entries[cmpl_addr].done <= 1'b1;
      if (do_commit) begin
        entries[head[AW-1:0]].valid <= 1'b0;
        entries[head[AW-1:0]].done  <= 1'b0;
      end
      if (do_alloc) begin
        entries[tail[AW-1:0]] <= '{valid: 1'b1, done: 1'b0, arch_rd: alloc_arch_rd,
                                   phy_rd: alloc_phy_rd, has_rd: alloc_has_rd};
      end
    end
  end

  // Registered retirement and busy-table clear outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_en          <= 1'b0;
      commit_arch_rd     <= '0;
      commit_phy_rd      <= '0;
      commit_has_rd      <= 1'b0;
      busy_table_wr_en   <= 1'b0;
      busy_table_wr_addr <= '0;
      busy_table_wr_data <= 1'b0;
    end else begin
      commit_en          <= do_commit && !flush;
      busy_table_wr_en   <= do_cmpl && cmpl_ent.has_rd && !flush;
      busy_table_wr_data <= 1'b0;
      if (do_commit) begin
        commit_arch_rd <= head_ent.arch_rd;
        commit_phy_rd  <= head_ent.phy_rd;
        commit_has_rd  <= head_ent.has_rd;
      end
      if (do_cmpl) busy_table_wr_addr <= cmpl_ent.phy_rd;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob against a queue-based reference model.
module tb_rob;
  import qu_common::*;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_en = 1'b0;
  logic [4:0] alloc_arch_rd = '0;
  logic [5:0] alloc_phy_rd = '0;
  logic       alloc_has_rd = 1'b0;
  logic [3:0] tail_ptr;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       cmpl_en = 1'b0;
  logic [3:0] cmpl_addr = '0;
  logic       commit_en;
  logic [4:0] commit_arch_rd;
  logic [5:0] commit_phy_rd;
  logic       commit_has_rd;
  logic       busy_table_wr_en;
  logic [5:0] busy_table_wr_addr;
  logic       busy_table_wr_data;
  logic       flush = 1'b0;

  int total = 0;
  int bad   = 0;

  rob #(.ROB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_arch_rd(alloc_arch_rd), .alloc_phy_rd(alloc_phy_rd),
    .alloc_has_rd(alloc_has_rd), .tail_ptr(tail_ptr), .full(full), .empty(empty),
    .count(count), .cmpl_en(cmpl_en), .cmpl_addr(cmpl_addr),
    .commit_en(commit_en), .commit_arch_rd(commit_arch_rd), .commit_phy_rd(commit_phy_rd),
    .commit_has_rd(commit_has_rd), .busy_table_wr_en(busy_table_wr_en),
    .busy_table_wr_addr(busy_table_wr_addr), .busy_table_wr_data(busy_table_wr_data),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    int         idx;
    logic [4:0] arch;
    logic [5:0] phy;
    logic       has;
    logic       done;
  } ment_t;

  ment_t      mq[$];
  int         m_tail = 0;
  logic       e_cen = 1'b0;
  logic [4:0] e_arch = '0;
  logic [5:0] e_phy = '0;
  logic       e_has = 1'b0;
  logic       e_ben = 1'b0;
  logic [5:0] e_baddr = '0;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_cen = 1'b0; e_arch = '0; e_phy = '0; e_has = 1'b0;
    e_ben = 1'b0; e_baddr = '0;
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic step(input bit a, input logic [4:0] ar, input logic [5:0] pr, input bit h,
                      input bit c, input logic [3:0] ca, input bit f);
    bit will_commit;
    bit was_full;
    alloc_en = a; alloc_arch_rd = ar; alloc_phy_rd = pr; alloc_has_rd = h;
    cmpl_en = c; cmpl_addr = ca; flush = f;
    will_commit = (mq.size() > 0) && mq[0].done;
    was_full = (mq.size() == DEPTH);
    if (f) begin
      mq.delete();
      m_tail = 0;
      e_cen = 1'b0;
      e_ben = 1'b0;
    end else begin
      e_cen = will_commit;
      if (will_commit) begin
        e_arch = mq[0].arch; e_phy = mq[0].phy; e_has = mq[0].has;
      end
      e_ben = 1'b0;
      if (c) begin
        foreach (mq[i]) begin
          if (mq[i].idx == int'(ca) && !mq[i].done) begin
            mq[i].done = 1'b1;
            if (mq[i].has) begin
              e_ben = 1'b1;
              e_baddr = mq[i].phy;
            end
          end
        end
      end
      if (will_commit) void'(mq.pop_front());
      if (a && !was_full) begin
        mq.push_back('{idx: m_tail, arch: ar, phy: pr, has: h, done: 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alloc_en = 1'b1; cmpl_en = 1'b1; flush = 1'b1; cmpl_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || tail_ptr !== 4'd0) begin
      bad++; $display("FAIL reset_occ count=%0d empty=%b full=%b tail=%0d exp 0/1/0/0", count, empty, full, tail_ptr); end
    total++; if (commit_en !== 1'b0 || commit_arch_rd !== 5'd0 || commit_phy_rd !== 6'd0 || commit_has_rd !== 1'b0) begin
      bad++; $display("FAIL reset_commit en=%b arch=%0d phy=%0d has=%b exp all 0", commit_en, commit_arch_rd, commit_phy_rd, commit_has_rd); end
    total++; if (busy_table_wr_en !== 1'b0 || busy_table_wr_addr !== 6'd0 || busy_table_wr_data !== 1'b0) begin
      bad++; $display("FAIL reset_busy en=%b addr=%0d data=%b exp all 0", busy_table_wr_en, busy_table_wr_addr, busy_table_wr_data); end
    alloc_en = 1'b0; cmpl_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_alloc3();
    step(1'b1, 5'd1, 6'd33, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 5'd2, 6'd34, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 5'd3, 6'd35, 1'b1, 1'b0, '0, 1'b0);
    total++; if (tail_ptr !== 4'd3 || count !== 5'd3) begin
      bad++; $display("FAIL alloc3_ptr tail=%0d count=%0d exp 3/3", tail_ptr, count); end
    total++; if (empty !== 1'b0 || commit_en !== 1'b0) begin
      bad++; $display("FAIL alloc3_flags empty=%b commit_en=%b exp 0/0", empty, commit_en); end
  endtask

  task automatic test_in_order_commit();
    logic [5:0] exp_phy [3];
    exp_phy[0] = 6'd33; exp_phy[1] = 6'd34; exp_phy[2] = 6'd35;
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd2, 1'b0);
    total++; if (commit_en !== 1'b0 || busy_table_wr_en !== 1'b1 || busy_table_wr_addr !== 6'd35) begin
      bad++; $display("FAIL cmpl2 commit_en=%b bt_en=%b bt_addr=%0d exp 0/1/35", commit_en, busy_table_wr_en, busy_table_wr_addr); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    total++; if (commit_en !== 1'b0) begin
      bad++; $display("FAIL cmpl1_nocommit commit_en=%b exp 0", commit_en); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b0);
    total++; if (commit_en !== 1'b0) begin
      bad++; $display("FAIL cmpl0_nocommit commit_en=%b exp 0", commit_en); end
    for (int k = 0; k < 3; k++) begin
      idle();
      total++; if (commit_en !== 1'b1 || commit_phy_rd !== exp_phy[k] || commit_arch_rd !== 5'(k + 1)) begin
        bad++; $display("FAIL commit_seq%0d en=%b phy=%0d arch=%0d exp 1/%0d/%0d", k, commit_en, commit_phy_rd, commit_arch_rd, exp_phy[k], k + 1); end
    end
    total++; if (count !== 5'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL drained count=%0d empty=%b exp 0/1", count, empty); end
    idle();
    total++; if (commit_en !== 1'b0) begin
      bad++; $display("FAIL post_drain commit_en=%b exp 0", commit_en); end
  endtask

  task automatic test_full_wrap();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 5'(k), 6'(k + 20), 1'b1, 1'b0, '0, 1'b0);
    total++; if (full !== 1'b1 || tail_ptr !== 4'd0 || count !== 5'd16) begin
      bad++; $display("FAIL full16 full=%b tail=%0d count=%0d exp 1/0/16", full, tail_ptr, count); end
    step(1'b1, 5'd31, 6'd63, 1'b1, 1'b0, '0, 1'b0);
    total++; if (tail_ptr !== 4'd0 || count !== 5'd16) begin
      bad++; $display("FAIL alloc17 tail=%0d count=%0d exp 0/16", tail_ptr, count); end
    step(1'b1, 5'd30, 6'd50, 1'b0, 1'b1, 4'd0, 1'b0);
    total++; if (count !== 5'd16 || full !== 1'b1) begin
      bad++; $display("FAIL full_cmpl count=%0d full=%b exp 16/1", count, full); end
    step(1'b1, 5'd30, 6'd50, 1'b0, 1'b0, '0, 1'b0);
    total++; if (commit_en !== 1'b1 || commit_phy_rd !== 6'd20 || count !== 5'd15 || tail_ptr !== 4'd0 || full !== 1'b0) begin
      bad++; $display("FAIL full_commit en=%b phy=%0d count=%0d tail=%0d full=%b exp 1/20/15/0/0", commit_en, commit_phy_rd, count, tail_ptr, full); end
    step(1'b1, 5'd30, 6'd50, 1'b0, 1'b0, '0, 1'b0);
    total++; if (tail_ptr !== 4'd1 || count !== 5'd16 || full !== 1'b1) begin
      bad++; $display("FAIL wrap_alloc tail=%0d count=%0d full=%b exp 1/16/1", tail_ptr, count, full); end
  endtask

  task automatic test_busy_table();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 5'd7, 6'd40, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 5'd8, 6'd41, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b0);
    total++; if (busy_table_wr_en !== 1'b1 || busy_table_wr_addr !== 6'd40 || busy_table_wr_data !== 1'b0) begin
      bad++; $display("FAIL bt_write en=%b addr=%0d data=%b exp 1/40/0", busy_table_wr_en, busy_table_wr_addr, busy_table_wr_data); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd5, 1'b0);
    total++; if (busy_table_wr_en !== 1'b0) begin
      bad++; $display("FAIL bt_empty_slot en=%b exp 0", busy_table_wr_en); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    total++; if (busy_table_wr_en !== 1'b0) begin
      bad++; $display("FAIL bt_no_rd en=%b exp 0", busy_table_wr_en); end
  endtask

  task automatic test_flush();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 5'(k + 10), 6'(k + 1), 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b0);
    step(1'b1, 5'd9, 6'd9, 1'b1, 1'b1, 4'd2, 1'b1);
    total++; if (count !== 5'd0 || tail_ptr !== 4'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL flush_occ count=%0d tail=%0d empty=%b exp 0/0/1", count, tail_ptr, empty); end
    total++; if (commit_en !== 1'b0 || busy_table_wr_en !== 1'b0) begin
      bad++; $display("FAIL flush_out commit_en=%b bt_en=%b exp 0/0", commit_en, busy_table_wr_en); end
    idle();
    total++; if (commit_en !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL post_flush commit_en=%b count=%0d exp 0/0", commit_en, count); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) step(1'b1, 5'(k), 6'(k + 50), 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd2, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd3, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || tail_ptr !== 4'd0) begin
      bad++; $display("FAIL rst_mid_occ count=%0d empty=%b full=%b tail=%0d exp 0/1/0/0", count, empty, full, tail_ptr); end
    total++; if (commit_en !== 1'b0 || busy_table_wr_en !== 1'b0 || busy_table_wr_addr !== 6'd0 || commit_phy_rd !== 6'd0) begin
      bad++; $display("FAIL rst_mid_out commit_en=%b bt_en=%b bt_addr=%0d cphy=%0d exp 0/0/0/0", commit_en, busy_table_wr_en, busy_table_wr_addr, commit_phy_rd); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 4'(k), 1'b0);
      total++; if (commit_en !== 1'b0 || busy_table_wr_en !== 1'b0 || count !== 5'd0) begin
        bad++; $display("FAIL rst_release%0d commit_en=%b bt_en=%b count=%0d exp 0/0/0", k, commit_en, busy_table_wr_en, count); end
    end
  endtask

  task automatic test_random();
    bit         a, h, c, f;
    logic [4:0] ar;
    logic [5:0] pr;
    logic [3:0] ca;
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 9) < 6);
      h  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 1) == 1);
      f  = ($urandom_range(0, 49) == 0);
      ar = 5'($urandom_range(0, 31));
      pr = 6'($urandom_range(0, 63));
      ca = 4'($urandom_range(0, 15));
      step(a, ar, pr, h, c, ca, f);
      total++; if (count !== 5'(mq.size()) || tail_ptr !== 4'(m_tail)) begin
        bad++; $display("FAIL rnd_ptr cyc=%0d count=%0d tail=%0d exp %0d/%0d", n, count, tail_ptr, mq.size(), m_tail); end
      total++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        bad++; $display("FAIL rnd_flags cyc=%0d full=%b empty=%b exp size %0d", n, full, empty, mq.size()); end
      total++; if (commit_en !== e_cen || (e_cen && (commit_arch_rd !== e_arch || commit_phy_rd !== e_phy || commit_has_rd !== e_has))) begin
        bad++; $display("FAIL rnd_commit cyc=%0d en=%b arch=%0d phy=%0d has=%b exp %b/%0d/%0d/%b", n, commit_en, commit_arch_rd, commit_phy_rd, commit_has_rd, e_cen, e_arch, e_phy, e_has); end
      total++; if (busy_table_wr_en !== e_ben || (e_ben && (busy_table_wr_addr !== e_baddr || busy_table_wr_data !== 1'b0))) begin
        bad++; $display("FAIL rnd_busy cyc=%0d en=%b addr=%0d data=%b exp %b/%0d/0", n, busy_table_wr_en, busy_table_wr_addr, busy_table_wr_data, e_ben, e_baddr); end
      // Occasionally drain everything that is outstanding so commits keep flowing.
      if (n % 60 == 59) begin
        foreach (mq[i]) begin
          step(1'b0, '0, '0, 1'b0, 1'b1, 4'(mq[i].idx), 1'b0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc3();
    test_in_order_commit();
    test_full_wrap();
    test_busy_table();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
